// File: rtl/gb_burst_read.sv
// Line fetcher: pulls one line of 16-bit pixels from PSRAM as fixed-length bursts
// into a ping-pong buffer and serves the completed line to scanout.
module gb_burst_read #(
  parameter int LINE_WORDS  = 160,
  parameter int BURST_LEN   = 32,
  parameter int LINE_STRIDE = 160
) (
  input  logic        xClk,
  input  logic        xRst,
  input  logic [22:0] xBaseAddr,
  input  logic [7:0]  xLine,
  input  logic        xLineReq,
  input  logic        xRamReady,
  output logic        xMcuReqRead,
  output logic [22:0] xAddress,
  input  logic        xWrEn,
  input  logic [15:0] xDin,
  input  logic [7:0]  xPixAddr,
  output logic [15:0] xPixData,
  output logic        xLineDone,
  output logic        xBusy,
  output logic        xOverrun,
  output logic        xProtoErr
);

  localparam int WC_W = $clog2(LINE_WORDS + 1);
  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam int IX_W = $clog2(LINE_WORDS);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(LINE_WORDS - 1);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_r;
  state_t            stateNext_s;
  logic [22:0]       lineAddr_r;
  logic [22:0]       lineOffset_s;
  logic [WC_W-1:0]   wordCnt_r;
  logic [BC_W-1:0]   beatCnt_r;
  logic              dispBank_r;
  logic              dispBankNext_s;
  logic              acceptReq_s;
  logic              issueReq_s;
  logic              beatWr_s;
  logic              lineEnd_s;
  logic [IX_W-1:0]   wrIdx_s;
  logic [IX_W-1:0]   rdIdx_s;
  logic [15:0]       pixNext_s;
  logic [15:0]       bank0_r [LINE_WORDS];
  logic [15:0]       bank1_r [LINE_WORDS];

  assign lineOffset_s   = {15'd0, xLine} * 23'(LINE_STRIDE);
  assign wrIdx_s        = wordCnt_r[IX_W-1:0];
  assign rdIdx_s        = xPixAddr[IX_W-1:0];
  assign dispBankNext_s = lineEnd_s ? ~dispBank_r : dispBank_r;

  // FSM state register
  always_ff @(posedge xClk) begin
    if (xRst) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state decode; the last beat of the line ends the fill on the same edge
  always_comb begin
    stateNext_s = state_r;
    acceptReq_s = 1'b0;
    issueReq_s  = 1'b0;
    beatWr_s    = 1'b0;
    lineEnd_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (xLineReq) begin
          acceptReq_s = 1'b1;
          stateNext_s = REQ;
        end else begin
          stateNext_s = IDLE;
        end
      end
      REQ: begin
        if (xRamReady) begin
          issueReq_s  = 1'b1;
          stateNext_s = DATA;
        end else begin
          stateNext_s = REQ;
        end
      end
      DATA: begin
        if (xWrEn) begin
          beatWr_s = 1'b1;
          if (beatCnt_r == LAST_BEAT) begin
            if (wordCnt_r == LAST_WORD) begin
              lineEnd_s   = 1'b1;
              stateNext_s = IDLE;
            end else begin
              stateNext_s = REQ;
            end
          end else begin
            stateNext_s = DATA;
          end
        end else begin
          stateNext_s = DATA;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // Counters, bank select, controller request and status outputs
  always_ff @(posedge xClk) begin
    if (xRst) begin
      lineAddr_r  <= 23'd0;
      wordCnt_r   <= '0;
      beatCnt_r   <= '0;
      dispBank_r  <= 1'b0;
      xMcuReqRead <= 1'b0;
      xAddress    <= 23'd0;
      xLineDone   <= 1'b0;
      xBusy       <= 1'b0;
      xOverrun    <= 1'b0;
      xProtoErr   <= 1'b0;
    end else begin
      xMcuReqRead <= issueReq_s;
      xLineDone   <= lineEnd_s;
      xBusy       <= (stateNext_s != IDLE);
      dispBank_r  <= dispBankNext_s;
      if (xLineReq && (state_r != IDLE)) begin
        xOverrun <= 1'b1;
      end
      if (xWrEn && (state_r != DATA)) begin
        xProtoErr <= 1'b1;
      end
      if (acceptReq_s) begin
        lineAddr_r <= xBaseAddr + lineOffset_s;
        wordCnt_r  <= '0;
      end
      // wordCnt is always a whole number of bursts here, so it is the burst offset
      if (issueReq_s) begin
        xAddress  <= lineAddr_r + 23'(wordCnt_r);
        beatCnt_r <= '0;
      end
      if (beatWr_s) begin
        wordCnt_r <= wordCnt_r + WC_W'(1'b1);
        beatCnt_r <= beatCnt_r + BC_W'(1'b1);
      end
    end
  end

  // Fill writes always target the bank not on display
  always_ff @(posedge xClk) begin
    if (beatWr_s && !xRst) begin
      if (dispBank_r) begin
        bank0_r[wrIdx_s] <= xDin;
      end else begin
        bank1_r[wrIdx_s] <= xDin;
      end
    end
  end

  // Reads use the post-swap bank; forward the final beat on the swap edge
  always_comb begin
    pixNext_s = 16'h0000;
    if ({1'b0, xPixAddr} < 9'(LINE_WORDS)) begin
      if (lineEnd_s && (wrIdx_s == rdIdx_s)) begin
        pixNext_s = xDin;
      end else if (dispBankNext_s) begin
        pixNext_s = bank1_r[rdIdx_s];
      end else begin
        pixNext_s = bank0_r[rdIdx_s];
      end
    end else begin
      pixNext_s = 16'h0000;
    end
  end

  // Registered pixel port
  always_ff @(posedge xClk) begin
    if (xRst) begin
      xPixData <= 16'h0000;
    end else begin
      xPixData <= pixNext_s;
    end
  end

endmodule

// File: tb/tb_gb_burst_read.sv
// Bench for gb_burst_read: controller model plus a line-level reference model of
// what the display should show and which burst addresses must be requested.
module tb_gb_burst_read;

  localparam int LW = 160;
  localparam int BL = 32;
  localparam int LS = 160;

  logic        xClk = 1'b0;
  logic        xRst;
  logic [22:0] xBaseAddr;
  logic [7:0]  xLine;
  logic        xLineReq;
  logic        xRamReady;
  logic        xMcuReqRead;
  logic [22:0] xAddress;
  logic        xWrEn;
  logic [15:0] xDin;
  logic [7:0]  xPixAddr;
  logic [15:0] xPixData;
  logic        xLineDone;
  logic        xBusy;
  logic        xOverrun;
  logic        xProtoErr;

  always #5 xClk = ~xClk;

  gb_burst_read #(.LINE_WORDS(LW), .BURST_LEN(BL), .LINE_STRIDE(LS)) dut (
    .xClk(xClk), .xRst(xRst), .xBaseAddr(xBaseAddr), .xLine(xLine),
    .xLineReq(xLineReq), .xRamReady(xRamReady), .xMcuReqRead(xMcuReqRead),
    .xAddress(xAddress), .xWrEn(xWrEn), .xDin(xDin), .xPixAddr(xPixAddr),
    .xPixData(xPixData), .xLineDone(xLineDone), .xBusy(xBusy),
    .xOverrun(xOverrun), .xProtoErr(xProtoErr)
  );

  int          tests = 0;
  int          fails = 0;
  logic [22:0] reqQ[$];
  int          totalBeats = 0;
  int          flushReq = 0;
  int          injectReq = 0;
  logic [15:0] dataKey = 16'h0000;
  bit          readyRandom = 1'b0;
  bit          readyForce = 1'b1;
  bit          gapMode = 1'b0;
  logic [22:0] dispLineAddr = 23'd0;
  int          reqBase;
  int          beatBase;

  typedef struct {
    logic [22:0] base;
    logic [7:0]  line;
    logic [22:0] firstAddr;
    logic [15:0] firstPix;
  } vec_t;
  vec_t tbl[5];

  function automatic logic [15:0] dataOf(input logic [22:0] a);
    return a[15:0] ^ dataKey;
  endfunction

  function automatic logic [22:0] lineAddrOf(input logic [22:0] b, input logic [7:0] l);
    logic [31:0] t;
    t = 32'(b) + 32'(l) * LS;
    return t[22:0];
  endfunction

  function automatic logic [15:0] expPix(input int p);
    if (p >= LW) return 16'h0000;
    return dataOf(dispLineAddr + 23'(p));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Controller model: one burst of BL beats per request, data derived from address
  initial begin : controller
    int          beatsLeft;
    int          flushSeen;
    int          injectSeen;
    logic [22:0] beatAddr;
    beatsLeft = 0; flushSeen = 0; injectSeen = 0; beatAddr = 23'd0;
    xWrEn = 1'b0; xDin = 16'h0000; xRamReady = 1'b0;
    forever begin
      @(negedge xClk);
      if (flushReq != flushSeen) begin
        flushSeen = flushReq;
        beatsLeft = 0;
      end
      xRamReady = readyRandom ? ($urandom_range(0, 3) != 0) : readyForce;
      if (xMcuReqRead === 1'b1) begin
        reqQ.push_back(xAddress);
        beatsLeft = BL;
        beatAddr  = xAddress;
      end
      if (injectReq != injectSeen) begin
        injectSeen = injectReq;
        xWrEn = 1'b1;
        xDin  = 16'hDEAD;
      end else if (beatsLeft > 0 && (!gapMode || $urandom_range(0, 2) != 0)) begin
        xWrEn = 1'b1;
        xDin  = dataOf(beatAddr);
        beatAddr = beatAddr + 23'd1;
        beatsLeft--;
        totalBeats++;
      end else begin
        xWrEn = 1'b0;
      end
    end
  end

  task automatic startFetch(input logic [22:0] b, input logic [7:0] l, input bit timing);
    @(negedge xClk);
    reqBase  = reqQ.size();
    beatBase = totalBeats;
    xBaseAddr = b; xLine = l; xLineReq = 1'b1;
    @(negedge xClk);
    xLineReq = 1'b0;
    xBaseAddr = 23'($urandom); xLine = 8'($urandom);
    check("busy_after_req", xBusy, 1);
    if (timing) begin
      check("req_not_yet", xMcuReqRead, 0);
      @(negedge xClk);
      check("req_pulse", xMcuReqRead, 1);
      check("first_addr", xAddress, lineAddrOf(b, l));
      @(negedge xClk);
      check("req_single", xMcuReqRead, 0);
    end
  endtask

  task automatic finishFetch(input logic [22:0] la);
    bit seen;
    seen = 1'b0;
    xPixAddr = 8'(LW - 1);
    for (int n = 0; n < 6000 && !seen; n++) begin
      @(negedge xClk);
      if (xLineDone === 1'b1) seen = 1'b1;
    end
    check("line_done_seen", seen, 1);
    if (seen) begin
      dispLineAddr = la;
      check("busy_low_at_done", xBusy, 0);
      check("swap_probe_pix", xPixData, expPix(LW - 1));
      @(negedge xClk);
      check("done_single", xLineDone, 0);
    end
    check("req_count", reqQ.size() - reqBase, LW / BL);
    for (int k = 0; k < LW / BL; k++) begin
      if (reqBase + k < reqQ.size())
        check($sformatf("req_addr%0d", k), reqQ[reqBase + k], la + 23'(k * BL));
    end
  endtask

  task automatic checkPix(input int p);
    @(negedge xClk);
    xPixAddr = 8'(p);
    @(negedge xClk);
    check($sformatf("pix%0d", p), xPixData, expPix(p));
  endtask

  task automatic checkAllPix();
    for (int p = 0; p < LW; p++) checkPix(p);
  endtask

  task automatic checkSomePix();
    checkPix(0); checkPix(LW - 1); checkPix(LW); checkPix(255);
    for (int i = 0; i < 12; i++) checkPix($urandom_range(0, LW - 1));
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [22:0] la;
    tbl[0] = '{23'h000000, 8'd0,   23'h000000, 16'h0000};
    tbl[1] = '{23'h7FFF00, 8'd3,   23'h0000E0, 16'h00E0};
    tbl[2] = '{23'h000100, 8'd1,   23'h0001A0, 16'h01A0};
    tbl[3] = '{23'h000000, 8'd255, 23'h009F60, 16'h9F60};
    tbl[4] = '{23'h7FFFFF, 8'd1,   23'h00009F, 16'h009F};

    xRst = 1'b1; xLineReq = 1'b0; xBaseAddr = 23'd0; xLine = 8'd0; xPixAddr = 8'd0;
    repeat (3) @(negedge xClk);
    check("rst_busy", xBusy, 0);
    check("rst_req", xMcuReqRead, 0);
    check("rst_done", xLineDone, 0);
    check("rst_overrun", xOverrun, 0);
    check("rst_protoerr", xProtoErr, 0);
    check("rst_addr", xAddress, 0);
    check("rst_pix", xPixData, 0);
    xRst = 1'b0;

    // Plain fetch with request timing, full readback of value == address
    startFetch(23'd0, 8'd0, 1'b1);
    finishFetch(23'd0);
    checkAllPix();

    // Table of base/line pairs, including 23-bit wrap
    for (int i = 0; i < 5; i++) begin
      startFetch(tbl[i].base, tbl[i].line, 1'b0);
      finishFetch(lineAddrOf(tbl[i].base, tbl[i].line));
      if (reqBase < reqQ.size())
        check($sformatf("tbl%0d_first_addr", i), reqQ[reqBase], tbl[i].firstAddr);
      @(negedge xClk);
      xPixAddr = 8'd0;
      @(negedge xClk);
      check($sformatf("tbl%0d_pix0", i), xPixData, tbl[i].firstPix);
    end

    // Controller not ready for 50 cycles while in REQ
    readyForce = 1'b0;
    repeat (2) @(negedge xClk);
    startFetch(23'h001000, 8'd2, 1'b0);
    repeat (50) @(negedge xClk);
    check("no_req_while_not_ready", reqQ.size() - reqBase, 0);
    check("busy_while_not_ready", xBusy, 1);
    readyForce = 1'b1;
    finishFetch(lineAddrOf(23'h001000, 8'd2));
    checkSomePix();

    // Line request mid-fill: dropped, overrun set, old line still displayed
    check("overrun_clear", xOverrun, 0);
    la = lineAddrOf(23'h020000, 8'd7);
    startFetch(23'h020000, 8'd7, 1'b0);
    repeat (40) @(negedge xClk);
    xLineReq = 1'b1; xBaseAddr = 23'h3ABCDE; xLine = 8'd99;
    @(negedge xClk);
    xLineReq = 1'b0;
    check("overrun_set", xOverrun, 1);
    check("busy_after_overrun", xBusy, 1);
    checkPix(0); checkPix(5); checkPix(LW - 2);
    finishFetch(la);
    checkSomePix();

    // Stray beat while idle
    check("protoerr_clear", xProtoErr, 0);
    @(negedge xClk);
    #2 injectReq++;
    repeat (3) @(negedge xClk);
    check("protoerr_set", xProtoErr, 1);
    check("busy_after_stray", xBusy, 0);
    checkAllPix();
    checkPix(200);

    // Randomized fetches with gappy beats and flaky ready
    readyRandom = 1'b1; gapMode = 1'b1;
    for (int r = 0; r < 8; r++) begin
      logic [22:0] b;
      logic [7:0]  l;
      dataKey = 16'($urandom);
      b = 23'($urandom);
      l = 8'($urandom);
      startFetch(b, l, 1'b0);
      finishFetch(lineAddrOf(b, l));
      checkSomePix();
    end
    readyRandom = 1'b0; gapMode = 1'b0;

    // Reset after two bursts, then a clean fetch
    startFetch(23'h004400, 8'd9, 1'b0);
    for (int n = 0; n < 2000 && (totalBeats - beatBase) < 2 * BL; n++) @(negedge xClk);
    check("two_bursts_seen", (totalBeats - beatBase) >= 2 * BL, 1);
    #2 xRst = 1'b1; flushReq++;
    @(negedge xClk);
    check("midrst_busy", xBusy, 0);
    check("midrst_req", xMcuReqRead, 0);
    check("midrst_done", xLineDone, 0);
    check("midrst_overrun", xOverrun, 0);
    check("midrst_protoerr", xProtoErr, 0);
    check("midrst_addr", xAddress, 0);
    check("midrst_pix", xPixData, 0);
    xRst = 1'b0;
    repeat (2) @(negedge xClk);
    startFetch(23'h004400, 8'd9, 1'b1);
    finishFetch(lineAddrOf(23'h004400, 8'd9));
    checkAllPix();
    check("protoerr_after_clean", xProtoErr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
